game_controller_n: RTL and testbench

GAME_CONTROLLER_N -- requirements
Module: game_controller_n

---
 rtl/game_controller_n.sv | 221 ++++++++++++++++++++++
 tb/tb_game_controller_n.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/game_controller_n.sv
// Snake-game control sequencer: execution loop, game/direction state, direction queue, LED row scan.
// Latency: one exec state per clka cycle; WAIT_LOGIC until logic_done or timeout, DISPLAY lasts ROWS*DISPLAY_CYCLES.
// Backpressure: the datapath stalls the loop by withholding logic_done; button presses beyond queue depth are dropped.
module game_controller_n #(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int DISPLAY_CYCLES = 2,
  parameter int DIR_DEPTH      = 2,
  parameter int LOGIC_TIMEOUT  = 255
) (
  input  logic                 clka,
  input  logic                 restart,
  input  logic [3:0]           direction_in,
  input  logic                 pause_in,
  input  logic                 logic_done,
  input  logic                 game_end,
  input  logic [ROWS*COLS-1:0] led_array,
  output logic [1:0]           game_state,
  output logic [1:0]           direction_state,
  output logic [2:0]           exec_state,
  output logic                 logic_tick,
  output logic                 no_update,
  output logic                 timeout_err,
  output logic [ROWS-1:0]      row_cathode,
  output logic [COLS-1:0]      column_anode
);

  localparam int RW = $clog2(ROWS);
  localparam int PW = 4;
  localparam int TW = 16;
  localparam int CW = $clog2(DIR_DEPTH + 1);

  typedef enum logic [1:0] {G_INIT = 2'd0, G_RUN = 2'd1, G_STOP = 2'd2, G_PAUSE = 2'd3} game_e;
  typedef enum logic [1:0] {D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3} dir_e;
  typedef enum logic [2:0] {
    X_UPDATE = 3'd0, X_CHECK = 3'd1, X_INPUT = 3'd2, X_WAIT = 3'd3, X_DISPLAY = 3'd4
  } exec_e;

  game_e                     game_q, game_d;
  logic [1:0]                dir_q, dir_d;
  exec_e                     exec_q, exec_d;
  logic [RW-1:0]             row_q, row_d;
  logic [PW-1:0]             pass_q, pass_d;
  logic [TW-1:0]             wait_q, wait_d;
  logic                      pend_end_q, pend_end_d;
  logic                      timeout_q, timeout_d;
  logic                      pause_prev_q;
  logic                      pause_pend_q, pause_pend_d;
  logic [3:0]                btn_prev_q;
  logic [DIR_DEPTH-1:0][1:0] q_q, q_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      tick_q, tick_d;
  logic                      nu_q, nu_d;

  logic       pause_edge, pause_hit;
  logic       onehot, rising, press;
  logic [1:0] press_dir, last_dir;
  logic       pop, reject, push_ok;
  logic [CW-1:0] cnt_pop;

  // Decode a new button press: one-hot, newly asserted, and only while the game accepts steering
  always_comb begin
    onehot    = (direction_in != 4'd0) && ((direction_in & (direction_in - 4'd1)) == 4'd0);
    rising    = |(direction_in & ~btn_prev_q);
    press     = onehot && rising && (game_q == G_INIT || game_q == G_RUN);
    case (direction_in)
      4'b0001: press_dir = D_UP;
      4'b0010: press_dir = D_DOWN;
      4'b0100: press_dir = D_LEFT;
      default: press_dir = D_RIGHT;
    endcase
  end

  // Direction queue: pop in INPUT, push checked against the entry that will be last after the pop
  always_comb begin
    q_d      = q_q;
    dir_d    = dir_q;
    pop      = (exec_q == X_INPUT) && (cnt_q != '0);
    last_dir = dir_q;
    for (int i = 0; i < DIR_DEPTH; i++) begin
      if (CW'(i + 1) == cnt_q) last_dir = q_q[i];
    end
    // UP/DOWN and LEFT/RIGHT differ only in bit 0, so flipping it gives the opposite heading
    reject  = (press_dir == last_dir) || (press_dir == (last_dir ^ 2'b01));
    cnt_pop = pop ? (cnt_q - CW'(1)) : cnt_q;
    push_ok = press && !reject && (cnt_pop < CW'(DIR_DEPTH));
    if (pop) begin
      dir_d = q_q[0];
      for (int i = 0; i < DIR_DEPTH - 1; i++) q_d[i] = q_q[i + 1];
    end
    cnt_d = cnt_pop;
    if (push_ok) begin
      for (int i = 0; i < DIR_DEPTH; i++) begin
        if (CW'(i) == cnt_pop) q_d[i] = press_dir;
      end
      cnt_d = cnt_pop + CW'(1);
    end
  end

  // Execution loop, game state transitions, datapath wait/timeout and scan counters
  always_comb begin
    exec_d       = exec_q;
    game_d       = game_q;
    row_d        = row_q;
    pass_d       = pass_q;
    wait_d       = wait_q;
    pend_end_d   = pend_end_q;
    timeout_d    = timeout_q;
    pause_edge   = pause_in && !pause_prev_q;
    pause_hit    = pause_pend_q || pause_edge;
    pause_pend_d = pause_hit;
    case (exec_q)
      X_UPDATE: begin
        if (game_q == G_RUN && pend_end_q)        game_d = G_STOP;
        else if (game_q == G_RUN && pause_hit)    game_d = G_PAUSE;
        else if (game_q == G_PAUSE && pause_hit)  game_d = G_RUN;
        else if (game_q == G_INIT && cnt_q != '0) game_d = G_RUN;
        pend_end_d   = 1'b0;
        pause_pend_d = 1'b0;
        exec_d       = X_CHECK;
      end
      X_CHECK: begin
        exec_d = (game_q == G_INIT || game_q == G_PAUSE) ? X_DISPLAY : X_INPUT;
      end
      X_INPUT: begin
        wait_d = '0;
        exec_d = X_WAIT;
      end
      X_WAIT: begin
        if (logic_done) begin
          pend_end_d = game_end;
          wait_d     = '0;
          exec_d     = X_DISPLAY;
        end else if (wait_q == TW'(LOGIC_TIMEOUT - 1)) begin
          // A silent datapath is treated as a crash so the game cannot hang in RUN
          timeout_d  = 1'b1;
          pend_end_d = 1'b1;
          wait_d     = '0;
          exec_d     = X_DISPLAY;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      X_DISPLAY: begin
        if (row_q == RW'(ROWS - 1)) begin
          row_d = '0;
          if (pass_q == PW'(DISPLAY_CYCLES - 1)) begin
            pass_d = '0;
            exec_d = X_UPDATE;
          end else begin
            pass_d = pass_q + PW'(1);
          end
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      default: exec_d = X_UPDATE;
    endcase
    tick_d = (exec_d == X_INPUT);
    nu_d   = (exec_d == X_INPUT) && (game_d == G_STOP);
  end

  // State registers with asynchronous restart
  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      game_q       <= G_INIT;
      dir_q        <= D_RIGHT;
      exec_q       <= X_UPDATE;
      row_q        <= '0;
      pass_q       <= '0;
      wait_q       <= '0;
      pend_end_q   <= 1'b0;
      timeout_q    <= 1'b0;
      pause_prev_q <= 1'b0;
      pause_pend_q <= 1'b0;
      btn_prev_q   <= 4'd0;
      q_q          <= '0;
      cnt_q        <= '0;
      tick_q       <= 1'b0;
      nu_q         <= 1'b0;
    end else begin
      game_q       <= game_d;
      dir_q        <= dir_d;
      exec_q       <= exec_d;
      row_q        <= row_d;
      pass_q       <= pass_d;
      wait_q       <= wait_d;
      pend_end_q   <= pend_end_d;
      timeout_q    <= timeout_d;
      pause_prev_q <= pause_in;
      pause_pend_q <= pause_pend_d;
      btn_prev_q   <= direction_in;
      q_q          <= q_d;
      cnt_q        <= cnt_d;
      tick_q       <= tick_d;
      nu_q         <= nu_d;
    end
  end

  // Row scan drive: column data follows led_array live so the display shows the current frame
  always_comb begin
    row_cathode  = '1;
    column_anode = '0;
    if (exec_q == X_DISPLAY) begin
      for (int r = 0; r < ROWS; r++) begin
        if (RW'(r) == row_q) begin
          row_cathode[r] = 1'b0;
          column_anode   = led_array[r*COLS +: COLS];
        end
      end
    end
  end

  assign game_state      = game_q;
  assign direction_state = dir_q;
  assign exec_state      = exec_q;
  assign logic_tick      = tick_q;
  assign no_update       = nu_q;
  assign timeout_err     = timeout_q;

endmodule

// File: tb/tb_game_controller_n.sv
// Directed bench for game_controller_n (8x8, two scan passes, queue depth 2, timeout 4).
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
// Every wait on the DUT is bounded; an expired wait is reported as a failed check.
module tb_game_controller_n;
  localparam int ROWS = 8;
  localparam int COLS = 8;

  localparam logic [2:0] X_UPDATE = 3'd0, X_CHECK = 3'd1, X_INPUT = 3'd2, X_WAIT = 3'd3, X_DISPLAY = 3'd4;
  localparam logic [1:0] G_INIT = 2'd0, G_RUN = 2'd1, G_STOP = 2'd2, G_PAUSE = 2'd3;
  localparam logic [1:0] D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3;
  localparam logic [3:0] B_UP = 4'b0001, B_DOWN = 4'b0010, B_LEFT = 4'b0100, B_RIGHT = 4'b1000;

  logic                 clka = 1'b0;
  logic                 restart;
  logic [3:0]           direction_in;
  logic                 pause_in;
  logic                 logic_done;
  logic                 game_end;
  logic [ROWS*COLS-1:0] led_array;
  logic [1:0]           game_state;
  logic [1:0]           direction_state;
  logic [2:0]           exec_state;
  logic                 logic_tick;
  logic                 no_update;
  logic                 timeout_err;
  logic [ROWS-1:0]      row_cathode;
  logic [COLS-1:0]      column_anode;

  logic [7:0] rowpat [8] = '{8'h01, 8'hA5, 8'h3C, 8'h80, 8'h7E, 8'h18, 8'hC3, 8'h5A};

  int checks = 0;
  int passes = 0;

  always #5 clka = ~clka;

  game_controller_n #(
    .ROWS(ROWS), .COLS(COLS), .DISPLAY_CYCLES(2), .DIR_DEPTH(2), .LOGIC_TIMEOUT(4)
  ) dut (
    .clka(clka), .restart(restart), .direction_in(direction_in), .pause_in(pause_in),
    .logic_done(logic_done), .game_end(game_end), .led_array(led_array),
    .game_state(game_state), .direction_state(direction_state), .exec_state(exec_state),
    .logic_tick(logic_tick), .no_update(no_update), .timeout_err(timeout_err),
    .row_cathode(row_cathode), .column_anode(column_anode)
  );

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_exec(input string tag, input logic [2:0] s);
    int n = 0;
    while (exec_state !== s && n < 60) begin
      step();
      n++;
    end
    chk({tag, ".reach"}, {29'd0, exec_state}, {29'd0, s});
  endtask

  task automatic press(input logic [3:0] b);
    direction_in = b;
    step();
    direction_in = 4'd0;
    step();
  endtask

  task automatic pause_pulse();
    pause_in = 1'b1;
    step();
    pause_in = 1'b0;
    step();
  endtask

  task automatic do_reset(input string tag);
    restart = 1'b1;
    step();
    step();
    chk({tag, ".game"},  {30'd0, game_state},      {30'd0, G_INIT});
    chk({tag, ".dir"},   {30'd0, direction_state}, {30'd0, D_RIGHT});
    chk({tag, ".exec"},  {29'd0, exec_state},      {29'd0, X_UPDATE});
    chk({tag, ".tick"},  {31'd0, logic_tick},      32'd0);
    chk({tag, ".nu"},    {31'd0, no_update},       32'd0);
    chk({tag, ".tmo"},   {31'd0, timeout_err},     32'd0);
    chk({tag, ".row"},   {24'd0, row_cathode},     32'hFF);
    chk({tag, ".col"},   {24'd0, column_anode},    32'h00);
    restart = 1'b0;
  endtask

  // Waits for INPUT, checks the tick, answers in the first WAIT cycle, lands in DISPLAY
  task automatic run_tick(input string tag, input logic [1:0] exp_dir, input logic exp_nu, input logic ge);
    wait_exec(tag, X_INPUT);
    chk({tag, ".tick"}, {31'd0, logic_tick}, 32'd1);
    chk({tag, ".nu"},   {31'd0, no_update},  {31'd0, exp_nu});
    step();
    chk({tag, ".wait"}, {29'd0, exec_state}, {29'd0, X_WAIT});
    chk({tag, ".dir"},  {30'd0, direction_state}, {30'd0, exp_dir});
    chk({tag, ".tick0"}, {31'd0, logic_tick}, 32'd0);
    logic_done = 1'b1;
    game_end   = ge;
    step();
    chk({tag, ".disp"}, {29'd0, exec_state}, {29'd0, X_DISPLAY});
    logic_done = 1'b0;
    game_end   = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_row;
    restart      = 1'b1;
    direction_in = 4'd0;
    pause_in     = 1'b0;
    logic_done   = 1'b0;
    game_end     = 1'b0;
    for (int r = 0; r < ROWS; r++) led_array[r*COLS +: COLS] = rowpat[r];

    do_reset("rst0");

    // Idle INIT frame: UPDATE, CHECK, then 16 scan cycles with no tick
    step();
    chk("idle.check", {29'd0, exec_state}, {29'd0, X_CHECK});
    step();
    for (int k = 0; k < 16; k++) begin
      exp_row = 8'hFF ^ (8'h01 << (k % 8));
      chk($sformatf("idle.exec%0d", k), {29'd0, exec_state}, {29'd0, X_DISPLAY});
      chk($sformatf("idle.row%0d", k),  {24'd0, row_cathode}, {24'd0, exp_row});
      chk($sformatf("idle.col%0d", k),  {24'd0, column_anode}, {24'd0, rowpat[k % 8]});
      chk($sformatf("idle.tick%0d", k), {31'd0, logic_tick}, 32'd0);
      step();
    end
    chk("idle.update", {29'd0, exec_state}, {29'd0, X_UPDATE});
    chk("idle.row_off", {24'd0, row_cathode}, 32'hFF);
    chk("idle.col_off", {24'd0, column_anode}, 32'h00);

    // UP in INIT: still INIT this frame, RUN next UPDATE, first tick pops UP
    press(B_UP);
    chk("start.init", {30'd0, game_state}, {30'd0, G_INIT});
    run_tick("t_up", D_UP, 1'b0, 1'b0);
    chk("start.run", {30'd0, game_state}, {30'd0, G_RUN});

    // LEFT, DOWN queued; RIGHT dropped because the queue is full
    press(B_LEFT);
    press(B_DOWN);
    press(B_RIGHT);
    run_tick("t_left", D_LEFT, 1'b0, 1'b0);
    press(B_UP);     // opposite of queued DOWN
    run_tick("t_down", D_DOWN, 1'b0, 1'b0);
    press(B_DOWN);   // equals heading with empty queue
    press(4'b0011);  // not one-hot
    run_tick("t_keep", D_DOWN, 1'b0, 1'b0);

    // Datapath silent: exactly four WAIT cycles, then timeout and STOP
    wait_exec("tmo", X_WAIT);
    chk("tmo.clear", {31'd0, timeout_err}, 32'd0);
    step(); step(); step();
    chk("tmo.wait4", {29'd0, exec_state}, {29'd0, X_WAIT});
    chk("tmo.still0", {31'd0, timeout_err}, 32'd0);
    step();
    chk("tmo.disp", {29'd0, exec_state}, {29'd0, X_DISPLAY});
    chk("tmo.set", {31'd0, timeout_err}, 32'd1);
    wait_exec("tmo.chk", X_CHECK);
    chk("tmo.stop", {30'd0, game_state}, {30'd0, G_STOP});
    run_tick("t_stop1", D_DOWN, 1'b1, 1'b0);
    press(B_LEFT);   // ignored in STOP
    run_tick("t_stop2", D_DOWN, 1'b1, 1'b0);
    chk("tmo.sticky", {31'd0, timeout_err}, 32'd1);
    chk("stop.hold", {30'd0, game_state}, {30'd0, G_STOP});

    // Restart mid-DISPLAY
    step(); step(); step();
    do_reset("rst_disp");

    // Rejected RIGHT keeps INIT; DOWN starts; game_end stops
    press(B_RIGHT);
    wait_exec("init.chk", X_CHECK);
    chk("init.hold", {30'd0, game_state}, {30'd0, G_INIT});
    press(B_DOWN);
    run_tick("t_end", D_DOWN, 1'b0, 1'b1);
    wait_exec("end.chk", X_CHECK);
    chk("end.stop", {30'd0, game_state}, {30'd0, G_STOP});

    // Restart mid-WAIT_LOGIC, loop restarts at UPDATE
    wait_exec("wl", X_WAIT);
    do_reset("rst_wait");
    step();
    chk("rst_wait.check", {29'd0, exec_state}, {29'd0, X_CHECK});

    // Pause edges toggle RUN/PAUSE; no ticks and no queued presses while paused
    press(B_UP);
    run_tick("t_p0", D_UP, 1'b0, 1'b0);
    pause_pulse();
    wait_exec("pz.chk", X_CHECK);
    chk("pz.pause", {30'd0, game_state}, {30'd0, G_PAUSE});
    step();
    chk("pz.skip", {29'd0, exec_state}, {29'd0, X_DISPLAY});
    chk("pz.notick", {31'd0, logic_tick}, 32'd0);
    press(B_LEFT);
    pause_pulse();
    wait_exec("pz.chk2", X_CHECK);
    chk("pz.run", {30'd0, game_state}, {30'd0, G_RUN});
    run_tick("t_p1", D_UP, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
